lcd_text_feeder: RTL and testbench
==================================

LCD_TEXT_FEEDER -- requirements
Module: lcd_text_feeder

Interface
REQ-001 Parameter DEPTH, default 8, is the number of entries in the character FIFO (power of two, 2..32).
REQ-002 Parameter COLS, default 16, is the number of characters per display line (two lines total).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_valid  input  1  upstream character-write request.
REQ-006 wr_char  input  8  ASCII character code.
REQ-007 wr_ready  output  1  FIFO not full; a write is accepted when wr_valid && wr_ready.
REQ-008 clear_req  input  1  single-cycle pulse requesting display clear and cursor home.
REQ-009 busy  input  1  busy from the downstream LCD controller.
REQ-010 lcd_enable  output  1  request to the downstream controller to execute lcd_bus.
REQ-011 lcd_bus  output  10  {rs, rw, data[7:0]} presented to the downstream controller.
REQ-012 cursor  output  5  current character position, 0..2*COLS-1.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-014 IDLE: when busy==0 and an item is pending, the FSM SHALL latch the item onto lcd_bus and enter ISSUE on the next edge.
REQ-015 Item priority SHALL be: pending clear, then pending line address, then the FIFO head.
REQ-016 ISSUE: lcd_enable SHALL be 1 for exactly one cycle, with the FSM unconditionally entering WAIT_ACK.
REQ-017 WAIT_ACK: lcd_enable SHALL stay 1 and lcd_bus stable until busy==1 is sampled, then lcd_enable SHALL drop to 0 and the FSM SHALL enter WAIT_DONE.
REQ-018 WAIT_DONE: on busy==0 the FSM SHALL return to IDLE; at most one item is issued per busy low-high-low cycle.
REQ-019 Clear item: lcd_bus SHALL be 10'h001 (rs=0, rw=0); on issue, cursor SHALL be set to 0.
REQ-020 Character item: lcd_bus SHALL be {1'b1, 1'b0, char}; the FIFO pops on entering ISSUE, and cursor increments on busy acknowledge.
REQ-021 When cursor increments from COLS-1 to COLS, a pending address 10'h0C0 SHALL be raised.
REQ-022 When cursor increments from 2*COLS-1, cursor SHALL wrap to 0 and a pending address 10'h080 SHALL be raised.
REQ-023 A line-address item SHALL clear its pending flag when issued and SHALL NOT change cursor.
REQ-024 clear_req SHALL flush the FIFO in the same cycle, set the pending clear flag, and drop any pending address.
REQ-025 A clear_req that arrives mid-transaction SHALL NOT disturb lcd_bus or lcd_enable of the in-flight item.
REQ-026 FIFO full: wr_ready SHALL be 0, and a write SHALL be ignored even if a pop occurs in the same cycle.
REQ-027 When clear_req and wr_valid occur in the same cycle, the flush SHALL win and the character SHALL be discarded.
REQ-028 FIFO empty with no pending flags: the FSM SHALL stay in IDLE with lcd_enable=0.
REQ-029 lcd_bus SHALL read 10'h000 whenever the FSM is in IDLE.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously set: FSM=IDLE, lcd_enable=0, lcd_bus=0, cursor=0, FIFO empty (wr_ready=1), all pending flags 0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction with no retry after release.
REQ-032 The first item after reset SHALL wait for busy==0, which covers the controller power-up/init window.

Structure
REQ-033 Shared package lcd_pkg SHALL hold the state enum and the constants CMD_CLEAR=8'h01, ADDR_LINE1=8'h80, ADDR_LINE2=8'hC0.
REQ-034 The FIFO SHALL be a sub-module lcd_char_fifo (DEPTH x 8, push/pop/full/empty/flush).

Verification
REQ-035 Bench: busy=1 for 100 cycles after reset, write 'A' (8'h41) -> lcd_enable stays 0 until busy falls, then lcd_bus=10'h241.
REQ-036 Bench: write 17 chars with the controller model acking each -> 16 character items, then 10'h0C0, then the 17th character; cursor=17.
REQ-037 Bench: write 9 chars while busy=1 -> wr_ready=0 after the 8th, the 9th is dropped, and exactly 8 characters are issued.
REQ-038 Bench: clear_req during WAIT_ACK of 'B' -> the 'B' item completes, then 10'h001 is issued, FIFO empty, cursor=0.
REQ-039 Bench: rst_n low during WAIT_ACK -> lcd_enable=0 immediately; no item is issued after release until a new write.
REQ-040 Bench: write 32 chars -> the item after the 32nd character is 10'h080, and cursor=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared state encoding and HD44780-style command bytes for the LCD text feeder.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] ADDR_LINE1 = 8'h80;
    localparam logic [7:0] ADDR_LINE2 = 8'hC0;

    // Bus word is {rs, rw, data}; the feeder only ever writes, so rw is always 0.
    function automatic logic [9:0] lcd_word(input logic rs, input logic [7:0] data);
        return {rs, 1'b0, data};
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Character FIFO, DEPTH x 8, with synchronous flush that overrides push.
module lcd_char_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/lcd_text_feeder.sv
// Feeds buffered characters, line addresses and clear commands to a busy-handshaked LCD controller.
module lcd_text_feeder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned COLS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_char,
    output logic       wr_ready,
    input  logic       clear_req,
    input  logic       busy,
    output logic       lcd_enable,
    output logic [9:0] lcd_bus,
    output logic [4:0] cursor
);
    import lcd_pkg::*;

    localparam logic [4:0] LINE1_LAST = 5'(COLS - 1);
    localparam logic [4:0] LINE2_LAST = 5'(2 * COLS - 1);

    lcd_state_t state;
    logic       pend_clear;
    logic       pend_addr;
    logic [7:0] addr_byte;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] fifo_head;

    assign wr_ready = !fifo_full;
    assign fifo_pop = (state == IDLE) && !busy && !pend_clear && !pend_addr && !fifo_empty;

    lcd_char_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_valid),
        .pop   (fifo_pop),
        .flush (clear_req),
        .din   (wr_char),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lcd_enable <= 1'b0;
            lcd_bus    <= '0;
            cursor     <= '0;
            pend_clear <= 1'b0;
            pend_addr  <= 1'b0;
            addr_byte  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    lcd_bus    <= '0;
                    lcd_enable <= 1'b0;
                    if (!busy) begin
                        if (pend_clear) begin
                            lcd_bus    <= lcd_word(1'b0, CMD_CLEAR);
                            lcd_enable <= 1'b1;
                            cursor     <= '0;
                            pend_clear <= 1'b0;
                            state      <= ISSUE;
                        end else if (pend_addr) begin
                            lcd_bus    <= lcd_word(1'b0, addr_byte);
                            lcd_enable <= 1'b1;
                            pend_addr  <= 1'b0;
                            state      <= ISSUE;
                        end else if (!fifo_empty) begin
                            lcd_bus    <= lcd_word(1'b1, fifo_head);
                            lcd_enable <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (busy) begin
                        lcd_enable <= 1'b0;
                        state      <= WAIT_DONE;
                        // rs=1 marks a character item; only those advance the cursor.
                        if (lcd_bus[9]) begin
                            if (cursor == LINE2_LAST) begin
                                cursor    <= '0;
                                pend_addr <= 1'b1;
                                addr_byte <= ADDR_LINE1;
                            end else begin
                                cursor <= cursor + 5'd1;
                                if (cursor == LINE1_LAST) begin
                                    pend_addr <= 1'b1;
                                    addr_byte <= ADDR_LINE2;
                                end
                            end
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        lcd_bus <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A new clear overrides both an address raised this cycle and a clear just issued.
            if (clear_req) begin
                pend_clear <= 1'b1;
                pend_addr  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed bench for lcd_text_feeder with an item-level reference model and busy-handshake controller model.
module tb_lcd_text_feeder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned COLS  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_char = '0;
    logic       wr_ready;
    logic       clear_req = 1'b0;
    logic       busy = 1'b1;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic [4:0] cursor;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [9:0] items[$];
    logic       m_clear = 1'b0;
    logic       m_addr_pend = 1'b0;
    logic [7:0] m_addr = '0;
    int         m_cursor = 0;
    logic       prev_en = 1'b0;
    logic [9:0] cur_item = '0;
    int         en_cycles = 0;

    // Controller model
    logic ctl_auto = 1'b0;
    logic man_busy = 1'b1;
    logic ctl_busy = 1'b0;
    int   ctl_cnt = 0;

    lcd_text_feeder #(
        .DEPTH(DEPTH),
        .COLS (COLS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_char   (wr_char),
        .wr_ready  (wr_ready),
        .clear_req (clear_req),
        .busy      (busy),
        .lcd_enable(lcd_enable),
        .lcd_bus   (lcd_bus),
        .cursor    (cursor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Controller: raise busy after seeing enable, hold it a few cycles, then release.
    initial begin
        forever begin
            @(negedge clk);
            if (!ctl_auto) begin
                busy     = man_busy;
                ctl_busy = 1'b0;
            end else if (!ctl_busy) begin
                if (lcd_enable && !busy) begin
                    busy     = 1'b1;
                    ctl_busy = 1'b1;
                    ctl_cnt  = 3;
                end
            end else begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    busy     = 1'b0;
                    ctl_busy = 1'b0;
                end
            end
        end
    end

    // Compare process: every issued item, handshake and cursor against the item-level model.
    initial begin
        logic [9:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                m_clear     = 1'b0;
                m_addr_pend = 1'b0;
                m_cursor    = 0;
                prev_en     = 1'b0;
                en_cycles   = 0;
            end else begin
                if (lcd_enable && !prev_en) begin
                    chk("issue_while_busy", 32'(busy), 32'd0);
                    if (m_clear) begin
                        exp      = 10'h001;
                        m_clear  = 1'b0;
                        m_cursor = 0;
                    end else if (m_addr_pend) begin
                        exp         = {2'b00, m_addr};
                        m_addr_pend = 1'b0;
                    end else if (mq.size() > 0) begin
                        exp = {2'b10, mq.pop_front()};
                    end else begin
                        exp = 10'h3FF;
                    end
                    chk("item", 32'(lcd_bus), 32'(exp));
                    items.push_back(lcd_bus);
                    cur_item  = lcd_bus;
                    en_cycles = 1;
                end else if (lcd_enable) begin
                    chk("bus_stable", 32'(lcd_bus), 32'(cur_item));
                    en_cycles++;
                end else if (prev_en) begin
                    chk("ack_busy", 32'(busy), 32'd1);
                    chk("enable_width", 32'(en_cycles >= 2), 32'd1);
                    if (cur_item[9]) begin
                        if (m_cursor == 2 * COLS - 1) begin
                            m_cursor    = 0;
                            m_addr      = 8'h80;
                            m_addr_pend = 1'b1;
                        end else begin
                            if (m_cursor == COLS - 1) begin
                                m_addr      = 8'hC0;
                                m_addr_pend = 1'b1;
                            end
                            m_cursor++;
                        end
                    end
                end
                if (clear_req) begin
                    mq.delete();
                    m_clear     = 1'b1;
                    m_addr_pend = 1'b0;
                end
                chk("cursor", 32'(cursor), 32'(m_cursor));
                chk("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
                if (!lcd_enable && !busy) begin
                    chk("bus_idle", 32'(lcd_bus), 32'd0);
                end
                prev_en = lcd_enable;
            end
        end
    end

    task automatic wr(input logic [7:0] c);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_char  = c;
        if (mq.size() < DEPTH) begin
            mq.push_back(c);
        end
        @(posedge clk);
        #2;
        wr_valid = 1'b0;
    endtask

    task automatic wr_wait(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("wr_ready_wait");
        wr(c);
    endtask

    task automatic do_clear(input logic with_wr, input logic [7:0] c);
        @(negedge clk);
        clear_req = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_char  = c;
        end
        @(posedge clk);
        #2;
        clear_req = 1'b0;
        wr_valid  = 1'b0;
    endtask

    task automatic wait_en(input int maxc);
        int n = 0;
        @(negedge clk);
        while (!lcd_enable && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) timeout("wait_enable");
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        @(negedge clk);
        while ((mq.size() != 0 || m_clear || m_addr_pend || lcd_enable || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) timeout("wait_idle");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] last_c;

        // Reset state, controller holding busy high through its power-up window
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_enable", 32'(lcd_enable), 32'd0);
        chk("rst_bus", 32'(lcd_bus), 32'd0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        rst_n = 1'b1;

        // First item waits for busy to fall
        wr(8'h41);
        repeat (100) @(negedge clk);
        chk("busy_hold_enable", 32'(lcd_enable), 32'd0);
        chk("busy_hold_items", 32'(items.size()), 32'd0);
        man_busy = 1'b0;
        repeat (2) @(negedge clk);
        ctl_auto = 1'b1;
        wait_en(20);
        chk("first_item_A", 32'(lcd_bus), 32'h241);
        wait_idle(200);
        chk("cursor_after_A", 32'(cursor), 32'd1);

        do_clear(1'b0, 8'h00);
        wait_idle(200);
        chk("clear_item", 32'(items[items.size()-1]), 32'h001);
        chk("cursor_after_clear", 32'(cursor), 32'd0);

        // 17 characters: line-2 address inserted before the 17th
        base = items.size();
        for (int i = 0; i < 17; i++) begin
            last_c = 8'h61 + 8'(i);
            wr_wait(last_c);
        end
        wait_idle(2000);
        chk("n17_count", 32'(items.size() - base), 32'd18);
        chk("n17_item16", 32'(items[base+15]), 32'h270);
        chk("n17_line2", 32'(items[base+16]), 32'h0C0);
        chk("n17_last", 32'(items[base+17]), 32'(10'h271));
        chk("n17_cursor", 32'(cursor), 32'd17);

        // 32 characters from home: wrap back to line 1
        do_clear(1'b0, 8'h00);
        wait_idle(200);
        base = items.size();
        for (int i = 0; i < 32; i++) begin
            wr_wait(8'h30 + 8'(i));
        end
        wait_idle(4000);
        chk("n32_count", 32'(items.size() - base), 32'd34);
        chk("n32_line2", 32'(items[base+16]), 32'h0C0);
        chk("n32_last_char", 32'(items[base+32]), 32'(10'h24F));
        chk("n32_wrap_addr", 32'(items[base+33]), 32'h080);
        chk("n32_cursor", 32'(cursor), 32'd0);

        // FIFO overflow while the controller is busy
        ctl_auto = 1'b0;
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        base = items.size();
        for (int i = 0; i < 8; i++) begin
            wr(8'h4B + 8'(i));
        end
        @(negedge clk);
        chk("full_after_8", 32'(wr_ready), 32'd0);
        wr(8'h7A);
        man_busy = 1'b0;
        repeat (2) @(negedge clk);
        ctl_auto = 1'b1;
        wait_idle(2000);
        chk("full_issued", 32'(items.size() - base), 32'd8);
        chk("full_last", 32'(items[base+7]), 32'(10'h252));
        chk("full_cursor", 32'(cursor), 32'd8);

        // Clear and write in the same cycle: only the clear is issued
        base = items.size();
        do_clear(1'b1, 8'h5A);
        wait_idle(200);
        chk("clr_wr_count", 32'(items.size() - base), 32'd1);
        chk("clr_wr_item", 32'(items[base]), 32'h001);
        chk("clr_wr_cursor", 32'(cursor), 32'd0);

        // Clear during WAIT_ACK of 'B' with 'C' still queued
        ctl_auto = 1'b0;
        man_busy = 1'b0;
        repeat (2) @(negedge clk);
        base = items.size();
        wr(8'h42);
        wr(8'h43);
        wait_en(20);
        repeat (2) @(negedge clk);
        do_clear(1'b0, 8'h00);
        @(negedge clk);
        chk("midclr_enable", 32'(lcd_enable), 32'd1);
        chk("midclr_bus", 32'(lcd_bus), 32'h242);
        ctl_auto = 1'b1;
        wait_idle(300);
        chk("midclr_count", 32'(items.size() - base), 32'd2);
        chk("midclr_second", 32'(items[base+1]), 32'h001);
        chk("midclr_empty", 32'(wr_ready), 32'd1);
        chk("midclr_cursor", 32'(cursor), 32'd0);

        // Reset during WAIT_ACK: abort without retry
        ctl_auto = 1'b0;
        man_busy = 1'b0;
        repeat (2) @(negedge clk);
        wr(8'h44);
        wait_en(20);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_enable", 32'(lcd_enable), 32'd0);
        chk("rst_mid_bus", 32'(lcd_bus), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = items.size();
        repeat (20) @(negedge clk);
        chk("rst_no_retry", 32'(items.size() - base), 32'd0);
        chk("rst_idle_enable", 32'(lcd_enable), 32'd0);
        wr(8'h45);
        ctl_auto = 1'b1;
        wait_idle(300);
        chk("post_rst_item", 32'(items[items.size()-1]), 32'h245);
        chk("post_rst_cursor", 32'(cursor), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
